control_unit: RTL and testbench

Opcode decoder for the simplified single-issue MIPS datapath. It maps the 4-bit instruction opcode `Op` to the register-file and ALU control signals `RegDst`, `ALUSrc`, `RegWrite` and `ALUControl`. These decode outputs are combinational. The block also holds a registered copy of the same control bundle, used as the decode-to-execute stage latch, with stall (enable) and flush controls.

---
 rtl/mips_pkg.sv | 51 +++++
 rtl/control_decode.sv | 44 ++++
 rtl/control_unit.sv | 69 ++++++
 tb/tb_control_unit.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the simplified single-issue MIPS datapath.
// Contents:
//   - opcode constants (OP_ADD .. OP_NOP)
//   - ALU operation codes
//   - the packed control bundle that travels from decode to execute
//   - NOP_BUNDLE, the all-zero bundle for NOPs, reserved opcodes, reset and flush
package mips_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_ADDI = 4'b0111;
  localparam logic [3:0] OP_NOP  = 4'b1000;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NAND = 4'b1101;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       reg_write;
    logic [3:0] alu_control;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t NOP_BUNDLE = '{
    reg_dst:     1'b0,
    alu_src:     1'b0,
    reg_write:   1'b0,
    alu_control: ALU_AND
  };

  // Bundle for an R-type register-register operation writing rd.
  function automatic ctrl_bundle_t rtype(input logic [3:0] alu);
    ctrl_bundle_t b;
    b.reg_dst     = 1'b1;
    b.alu_src     = 1'b0;
    b.reg_write   = 1'b1;
    b.alu_control = alu;
    return b;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Purely combinational opcode decoder.
// Ports:
//   op      in  4    instruction opcode
//   ctrl    out      decoded control bundle (NOP bundle for NOP and reserved codes)
//   illegal out 1    set when op is a reserved encoding (1001..1111)
module control_decode
  import mips_pkg::*;
(
  input  logic [3:0]   op,
  output ctrl_bundle_t ctrl,
  output logic         illegal
);

  // Decode table; the default arm covers reserved codes so every op value is defined.
  always_comb begin
    ctrl    = NOP_BUNDLE;
    illegal = 1'b0;
    case (op)
      OP_ADD:  ctrl = rtype(ALU_ADD);
      OP_SUB:  ctrl = rtype(ALU_SUB);
      OP_AND:  ctrl = rtype(ALU_AND);
      OP_OR:   ctrl = rtype(ALU_OR);
      OP_NOR:  ctrl = rtype(ALU_NOR);
      OP_NAND: ctrl = rtype(ALU_NAND);
      OP_SLT:  ctrl = rtype(ALU_SLT);
      OP_ADDI: begin
        ctrl.reg_dst     = 1'b0;
        ctrl.alu_src     = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = ALU_ADD;
      end
      OP_NOP: begin
        ctrl    = NOP_BUNDLE;
        illegal = 1'b0;
      end
      default: begin
        // Reserved opcodes must never write the register file.
        ctrl    = NOP_BUNDLE;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Opcode decoder plus decode-to-execute stage register.
// Ports:
//   clk, reset (sync, active-high)
//   Op          in  4   instruction opcode
//   En          in  1   stage-register load enable (0 = stall/hold)
//   Flush       in  1   load NOP bundle on next edge (overrides En=0)
//   RegDst, ALUSrc, RegWrite, ALUControl, Illegal   combinational decode
//   RegDstE, ALUSrcE, RegWriteE, ALUControlE, IllegalE   registered copies
module control_unit
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Op,
  input  logic       En,
  input  logic       Flush,
  output logic       RegDst,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic [3:0] ALUControl,
  output logic       Illegal,
  output logic       RegDstE,
  output logic       ALUSrcE,
  output logic       RegWriteE,
  output logic [3:0] ALUControlE,
  output logic       IllegalE
);

  ctrl_bundle_t ctrl_s;
  logic         illegal_s;
  ctrl_bundle_t ctrl_r;
  logic         illegal_r;

  control_decode u_decode (
    .op      (Op),
    .ctrl    (ctrl_s),
    .illegal (illegal_s)
  );

  assign RegDst     = ctrl_s.reg_dst;
  assign ALUSrc     = ctrl_s.alu_src;
  assign RegWrite   = ctrl_s.reg_write;
  assign ALUControl = ctrl_s.alu_control;
  assign Illegal    = illegal_s;

  // Stage register: reset, then flush, then load on enable, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_r    <= NOP_BUNDLE;
      illegal_r <= 1'b0;
    end else if (Flush) begin
      ctrl_r    <= NOP_BUNDLE;
      illegal_r <= 1'b0;
    end else if (En) begin
      ctrl_r    <= ctrl_s;
      illegal_r <= illegal_s;
    end else begin
      ctrl_r    <= ctrl_r;
      illegal_r <= illegal_r;
    end
  end

  assign RegDstE     = ctrl_r.reg_dst;
  assign ALUSrcE     = ctrl_r.alu_src;
  assign RegWriteE   = ctrl_r.reg_write;
  assign ALUControlE = ctrl_r.alu_control;
  assign IllegalE    = illegal_r;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios followed by
// randomized Op/En/Flush/reset traffic compared against a behavioural model.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Op;
  logic       En;
  logic       Flush;
  logic       RegDst, ALUSrc, RegWrite, Illegal;
  logic [3:0] ALUControl;
  logic       RegDstE, ALUSrcE, RegWriteE, IllegalE;
  logic [3:0] ALUControlE;

  int checks = 0;
  int errors = 0;

  // Model state of the stage register, packed as {illegal, regdst, alusrc, regwrite, alu[3:0]}.
  logic [7:0] exp_e;

  // ALU code for each legal non-NOP opcode, in opcode order.
  logic [3:0] alu_tab [8] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                              4'b1100, 4'b1101, 4'b0111, 4'b0010};

  control_unit dut (
    .clk         (clk),
    .reset       (reset),
    .Op          (Op),
    .En          (En),
    .Flush       (Flush),
    .RegDst      (RegDst),
    .ALUSrc      (ALUSrc),
    .RegWrite    (RegWrite),
    .ALUControl  (ALUControl),
    .Illegal     (Illegal),
    .RegDstE     (RegDstE),
    .ALUSrcE     (ALUSrcE),
    .RegWriteE   (RegWriteE),
    .ALUControlE (ALUControlE),
    .IllegalE    (IllegalE)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  wire [7:0] comb_obs = {Illegal, RegDst, ALUSrc, RegWrite, ALUControl};
  wire [7:0] e_obs    = {IllegalE, RegDstE, ALUSrcE, RegWriteE, ALUControlE};

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decode from the opcode rules: codes below 8 write a register,
  // only ADDI uses the immediate and rt, NOP is all zero, the rest are reserved.
  function automatic logic [7:0] ref_decode(input logic [3:0] op);
    logic [7:0] r;
    if (op < 4'd8) begin
      r = {1'b0, (op != 4'd7), (op == 4'd7), 1'b1, alu_tab[op[2:0]]};
    end else if (op == 4'd8) begin
      r = 8'h00;
    end else begin
      r = 8'h80;
    end
    return r;
  endfunction

  // One clock edge: update the model from the inputs seen at the edge, then check.
  task automatic tick(input string tag);
    logic [7:0] d;
    d = ref_decode(Op);
    @(posedge clk);
    if (reset || Flush) exp_e = 8'h00;
    else if (En)        exp_e = d;
    #1;
    check_val(tag, e_obs, exp_e);
    check_val({tag, "_comb"}, comb_obs, ref_decode(Op));
  endtask

  initial begin
    reset = 1'b1; En = 1'b0; Flush = 1'b0; Op = 4'd0;
    exp_e = 8'h00;

    // Combinational sweep over every opcode, one value per 10 time units.
    for (int i = 0; i < 16; i++) begin
      Op = 4'(i);
      #1;
      check_val("sweep", comb_obs, ref_decode(Op));
      if (i >= 9) check_val("reserved_nowrite", {7'd0, RegWrite}, 8'h00);
      #9;
    end

    // Reset with ADD on the bus, then release with En=1.
    Op = 4'b0000; reset = 1'b1; En = 1'b0;
    tick("reset");
    check_val("reset_zero", e_obs, 8'h00);
    reset = 1'b0; En = 1'b1;
    tick("load_add");
    check_val("load_add_fixed", e_obs, 8'b0_1_0_1_0010);

    // Load SUB, then stall while Op moves to ADDI.
    Op = 4'b0001;
    tick("load_sub");
    En = 1'b0; Op = 4'b0111;
    tick("stall_hold");
    check_val("stall_fixed", {ALUControlE, 4'd0}, 8'b0110_0000);
    check_val("stall_comb_addi", comb_obs, 8'b0_0_1_1_0010);

    // Flush wins over stall; then load NAND.
    Flush = 1'b1; Op = 4'b0101;
    tick("flush");
    Flush = 1'b0; En = 1'b1;
    tick("after_flush");
    check_val("nand_fixed", {ALUControlE, 4'd0}, 8'b1101_0000);

    // Reset and Flush together with En=1.
    reset = 1'b1; Flush = 1'b1;
    tick("reset_flush");

    // Decode is independent of the control inputs and the clock level.
    reset = 1'b0; Flush = 1'b0; Op = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      reset = k[0]; En = k[1]; Flush = k[2];
      #2;
      check_val("ctl_indep", comb_obs, 8'b0_1_0_1_1100);
    end
    reset = 1'b1;
    tick("resync");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      Op    = 4'($urandom_range(0, 15));
      En    = ($urandom_range(0, 3) != 0);
      Flush = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 15) == 0);
      #1;
      check_val("rand_comb_pre", comb_obs, ref_decode(Op));
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
